// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared select encodings, pipeline tag types and helpers for
//                the EX-stage operand forwarding controller.
//  Revision    : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // Width of a register index carried in the shadow tags
    localparam int REG_W = 5;

    // EX operand mux select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
    localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result now in MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // result now in WB
    localparam logic [1:0] FWD_ALT = 2'b11;  // PC or immediate

    // Shadow tag of the instruction sitting in EX
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } stage_tag_t;

    // Shadow tag of the instruction sitting in MEM; load status is no longer
    // needed once the value is on its way out of the memory stage
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } mem_tag_t;

    // A producer is worth forwarding from only if it really writes a
    // register other than x0
    function automatic logic ex_live(input stage_tag_t t);
        return t.valid && t.reg_write && (t.rd != '0);
    endfunction

    function automatic logic mem_live(input mem_tag_t t);
        return t.valid && t.reg_write && (t.rd != '0);
    endfunction

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_sel_logic.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_logic
//  Description : Per-operand forwarding select priority compare. Purely
//                combinational; one instance per EX operand.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_sel_logic
    import fwd_pkg::*;
#(
    parameter int XLEN_REGS = 5
) (
    input  logic                 i_force_alt,
    input  logic [XLEN_REGS-1:0] i_rs,
    input  logic                 i_ex_live,
    input  logic [XLEN_REGS-1:0] i_ex_rd,
    input  logic                 i_mem_live,
    input  logic [XLEN_REGS-1:0] i_mem_rd,
    output logic [1:0]           o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    // Liveness already excludes x0, so a zero source index can never hit
    assign w_ex_hit  = i_ex_live  && (i_ex_rd  == i_rs);
    assign w_mem_hit = i_mem_live && (i_mem_rd == i_rs);

    // Priority: forced PC/imm, youngest producer (EX), older producer (MEM)
    always_comb begin
        o_sel = FWD_RF;
        if (i_force_alt) begin
            o_sel = FWD_ALT;
        end else if (w_ex_hit) begin
            o_sel = FWD_MEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule : fwd_sel_logic
`default_nettype wire

// File: rtl/operand_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_forward_ctrl
//  Description : Forwarding and load-use hazard controller for a 5-stage
//                pipeline. Tracks EX/MEM destination tags, registers the EX
//                operand mux selects and raises a one-cycle load-use stall.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_forward_ctrl
    import fwd_pkg::*;
#(
    parameter int XLEN_REGS = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 id_valid,
    input  logic [XLEN_REGS-1:0] id_rs1,
    input  logic [XLEN_REGS-1:0] id_rs2,
    input  logic [XLEN_REGS-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_use_pc_a,
    input  logic                 id_use_imm_b,
    input  logic                 flush,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_count
);

    stage_tag_t       r_ex_tag;
    mem_tag_t         r_mem_tag;
    logic [1:0]       r_sel_a;
    logic [1:0]       r_sel_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_ex_live;
    logic             w_mem_live;
    logic             w_load_hit;
    logic             w_stall;
    logic             w_kill;
    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;

    assign w_ex_live  = ex_live(r_ex_tag);
    assign w_mem_live = mem_live(r_mem_tag);

    // A load in EX whose rd matches either ID source. Both sources count even
    // when the operand is overridden by PC/imm; the extra stall is harmless.
    assign w_load_hit = w_ex_live && r_ex_tag.mem_read &&
                        ((r_ex_tag.rd == id_rs1) || (r_ex_tag.rd == id_rs2));

    // A redirect kills the ID instruction, so it cannot create a hazard
    assign w_stall = id_valid && !flush && w_load_hit;
    assign w_kill  = flush || w_stall;

    fwd_sel_logic #(
        .XLEN_REGS (XLEN_REGS)
    ) u_sel_a (
        .i_force_alt (id_use_pc_a),
        .i_rs        (id_rs1),
        .i_ex_live   (w_ex_live),
        .i_ex_rd     (r_ex_tag.rd),
        .i_mem_live  (w_mem_live),
        .i_mem_rd    (r_mem_tag.rd),
        .o_sel       (w_sel_a)
    );

    fwd_sel_logic #(
        .XLEN_REGS (XLEN_REGS)
    ) u_sel_b (
        .i_force_alt (id_use_imm_b),
        .i_rs        (id_rs2),
        .i_ex_live   (w_ex_live),
        .i_ex_rd     (r_ex_tag.rd),
        .i_mem_live  (w_mem_live),
        .i_mem_rd    (r_mem_tag.rd),
        .o_sel       (w_sel_b)
    );

    // Advance shadow tags and capture the selects for the instruction entering EX
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ex_tag  <= '0;
            r_mem_tag <= '0;
            r_sel_a   <= FWD_RF;
            r_sel_b   <= FWD_RF;
        end else begin
            r_mem_tag.valid     <= r_ex_tag.valid;
            r_mem_tag.rd        <= r_ex_tag.rd;
            r_mem_tag.reg_write <= r_ex_tag.reg_write;
            if (w_kill) begin
                // Bubble: nothing valid enters EX, operands are don't-care
                r_ex_tag <= '0;
                r_sel_a  <= FWD_RF;
                r_sel_b  <= FWD_RF;
            end else begin
                r_ex_tag.valid     <= id_valid;
                r_ex_tag.rd        <= id_rd;
                r_ex_tag.reg_write <= id_reg_write;
                r_ex_tag.mem_read  <= id_mem_read;
                r_sel_a            <= w_sel_a;
                r_sel_b            <= w_sel_b;
            end
        end
    end

    // Count stalled cycles; wraps naturally at the counter width
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_a_sel   = r_sel_a;
    assign fwd_b_sel   = r_sel_b;
    assign stall       = w_stall;
    assign stall_count = r_stall_cnt;

endmodule : operand_forward_ctrl
`default_nettype wire

// File: tb/tb_operand_forward_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_forward_ctrl
//  Description : Self-checking bench for operand_forward_ctrl. Expected
//                selects are queued when an instruction is presented in ID
//                and compared once it has moved into EX.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_forward_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_use_pc_a;
    logic             id_use_imm_b;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } exp_sel_t;

    exp_sel_t sb_q[$];
    string    nm_q[$];

    operand_forward_ctrl #(
        .XLEN_REGS (5),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_use_pc_a  (id_use_pc_a),
        .id_use_imm_b (id_use_imm_b),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present one instruction in ID for one cycle, check stall in that cycle
    // and the selects it produces one cycle later
    task automatic issue(input string nm, input logic v,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic pca, input logic immb,
                         input logic fl, input logic exp_stall,
                         input logic [1:0] ea, input logic [1:0] eb);
        exp_sel_t e;
        string    en;
        @(negedge clk);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_use_pc_a  = pca;
        id_use_imm_b = immb;
        flush        = fl;
        #1;
        chk({nm, " stall"}, 32'(stall), 32'(exp_stall));
        sb_q.push_back('{a: ea, b: eb});
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e  = sb_q.pop_front();
            en = nm_q.pop_front();
            chk({en, " sel_a"}, 32'(fwd_a_sel), 32'(e.a));
            chk({en, " sel_b"}, 32'(fwd_b_sel), 32'(e.b));
        end
    endtask

    task automatic idle();
        issue("idle", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    // lw x8,0(x1) followed by add x9,x8,x8: stall, then resolve from WB
    task automatic load_use(input string nm, input logic [CNT_W-1:0] cnt_after);
        issue({nm, " lw"},    1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
        issue({nm, " add_s"}, 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        chk({nm, " count"}, 32'(stall_count), 32'(cnt_after));
        issue({nm, " add_r"}, 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
    endtask

    initial begin
        rst          = 1'b1;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        id_use_pc_a  = 1'b0;
        id_use_imm_b = 1'b0;
        flush        = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst sel_a", 32'(fwd_a_sel), 32'd0);
        chk("rst sel_b", 32'(fwd_b_sel), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x3 -> EX forward on A
        issue("add x5", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("sub x6", 1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        idle();
        idle();

        // add x5 ; nop ; or x7,x0,x5 -> B from WB, x0 never forwarded
        issue("add x5 b", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("nop",      1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
        issue("or x7",    1'b1, 5'd0, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        idle();
        idle();

        // Load-use: one stall cycle, bubble selects 00, then WB forwarding
        load_use("lu1", 4'd1);
        chk("lu1 count hold", 32'(stall_count), 32'd1);
        idle();
        idle();

        // addi x4 twice then add x10,x4,x4 -> EX wins over MEM, imm forces B
        issue("addi1", 1'b1, 5'd4, 5'd0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
        issue("addi2", 1'b1, 5'd4, 5'd0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b11);
        issue("add x10", 1'b1, 5'd4, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        // PC operand forces A regardless of a live producer
        issue("auipc", 1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11);
        idle();
        idle();

        // Flush beats the load-use hazard
        issue("fl lw",   1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
        issue("fl add",  1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        chk("fl count", 32'(stall_count), 32'd1);
        issue("fl next", 1'b1, 5'd8, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        idle();
        idle();

        // Drive the counter to its maximum, then wrap
        for (int k = 0; k < 14; k++) begin
            load_use("lup", 4'(k + 2));
        end
        chk("cnt max", 32'(stall_count), 32'd15);
        load_use("wrap", 4'd0);

        // Reset arriving in the middle of a stall cycle
        issue("rs lw", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
        load_use("pre", 4'd1);
        issue("rs lw2", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
        rst = 1'b1;
        issue("rs add", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        chk("rs count", 32'(stall_count), 32'd0);
        rst = 1'b0;
        issue("rs after", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        chk("rs count after", 32'(stall_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_operand_forward_ctrl
`default_nettype wire
